// File: rtl/sfp_pkg.sv
// Shared types and helpers for the multipass special-function processor.
// Saturation helpers work on a wide signed value and a target width.
package sfp_pkg;

  localparam int WIDE = 48;

  typedef logic signed [WIDE-1:0] wide_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  function automatic wide_t smax(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t smin(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic logic sat_hit(input wide_t v, input int w);
    return (v > smax(w)) || (v < smin(w));
  endfunction

  function automatic wide_t sat_clamp(input wide_t v, input int w);
    if (v > smax(w)) return smax(w);
    if (v < smin(w)) return smin(w);
    return v;
  endfunction

  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/sfp_mp_lane.sv
// Per-lane datapath: extend, accumulate, saturate, ReLU, shift, narrow.
// Purely combinational; the top decides when results are used.
module sfp_mp_lane
  import sfp_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int acc_bw  = 24,
  parameter int out_bw  = 16
) (
  input  logic [psum_bw-1:0] in_lane,
  input  logic [acc_bw-1:0]  acc_rd,
  input  logic               first,
  input  logic               relu,
  input  logic [3:0]         shift,
  output logic [acc_bw-1:0]  acc_wr,
  output logic [out_bw-1:0]  out_lane,
  output logic               acc_sat,
  output logic               out_sat
);

  wide_t ext;
  wide_t prev;
  wide_t sum;
  wide_t s;
  wide_t r;
  wide_t q;
  wide_t o;

  // Lane arithmetic chain from psum to narrowed output.
  always_comb begin
    ext      = wide_t'($signed(in_lane));
    prev     = wide_t'($signed(acc_rd));
    sum      = first ? ext : ext + prev;
    acc_sat  = sat_hit(sum, acc_bw);
    s        = sat_clamp(sum, acc_bw);
    r        = (relu && s[WIDE-1]) ? '0 : s;
    q        = r >>> shift;
    out_sat  = sat_hit(q, out_bw);
    o        = sat_clamp(q, out_bw);
    acc_wr   = s[acc_bw-1:0];
    out_lane = o[out_bw-1:0];
  end

endmodule

// File: rtl/sfp_multipass.sv
// Multipass accumulate / ReLU / shift / saturate stage at the psum output.
// FSM, pass/entry counters, accumulation buffer and output register.
module sfp_multipass
  import sfp_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int acc_bw  = 24,
  parameter int out_bw  = 16,
  parameter int depth   = 16,
  localparam int AW     = $clog2(depth)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AW:0]             cfg_depth,
  input  logic [7:0]              cfg_npass,
  input  logic                    cfg_relu,
  input  logic [3:0]              cfg_shift,
  output logic                    busy,
  output logic                    done,
  output logic                    sat_flag,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [psum_bw*col-1:0]  in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [out_bw*col-1:0]   out
);

  localparam logic [AW:0] DMAX = (AW+1)'(depth);

  state_t                  state;
  logic [AW:0]             d_q;
  logic [7:0]              p_q;
  logic [7:0]              pass;
  logic [AW-1:0]           ptr;
  logic                    relu_q;
  logic [3:0]              shift_q;
  logic [acc_bw*col-1:0]   mem [depth];

  logic [AW:0]             d_cl;
  logic [7:0]              p_cl;
  logic [acc_bw*col-1:0]   acc_rd;
  logic [acc_bw*col-1:0]   acc_wr_v;
  logic [out_bw*col-1:0]   out_v;
  logic [col-1:0]          acc_sat_v;
  logic [col-1:0]          out_sat_v;
  logic                    first;
  logic                    last;
  logic                    wrap;
  logic                    fire;
  logic                    sat_any;

  // Clamp the job configuration presented with start.
  always_comb begin
    d_cl = cfg_depth;
    if (cfg_depth == '0)
      d_cl = (AW+1)'(1);
    else if (cfg_depth > DMAX)
      d_cl = DMAX;
    p_cl = (cfg_npass == 8'd0) ? 8'd1 : cfg_npass;
  end

  // Handshake and position decode for the current beat.
  always_comb begin
    acc_rd   = mem[ptr];
    first    = (pass == 8'd0);
    last     = (pass == p_q - 8'd1);
    wrap     = ({1'b0, ptr} == d_q - (AW+1)'(1));
    busy     = (state != ST_IDLE);
    in_ready = (state == ST_RUN) && (!last || !out_valid || out_ready);
    done     = (state == ST_DRAIN) && (!out_valid || out_ready);
    fire     = in_valid && in_ready;
    sat_any  = (|acc_sat_v) || (last && (|out_sat_v));
  end

  for (genvar k = 0; k < col; k++) begin : g_lane
    sfp_mp_lane #(
      .psum_bw (psum_bw),
      .acc_bw  (acc_bw),
      .out_bw  (out_bw)
    ) u_lane (
      .in_lane  (in[lane_lo(k, psum_bw) +: psum_bw]),
      .acc_rd   (acc_rd[lane_lo(k, acc_bw) +: acc_bw]),
      .first    (first),
      .relu     (relu_q),
      .shift    (shift_q),
      .acc_wr   (acc_wr_v[lane_lo(k, acc_bw) +: acc_bw]),
      .out_lane (out_v[lane_lo(k, out_bw) +: out_bw]),
      .acc_sat  (acc_sat_v[k]),
      .out_sat  (out_sat_v[k])
    );
  end

  // Job FSM with entry pointer, pass counter and sticky saturation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      d_q      <= '0;
      p_q      <= '0;
      pass     <= '0;
      ptr      <= '0;
      relu_q   <= 1'b0;
      shift_q  <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            d_q      <= d_cl;
            p_q      <= p_cl;
            relu_q   <= cfg_relu;
            shift_q  <= cfg_shift;
            pass     <= '0;
            ptr      <= '0;
            sat_flag <= 1'b0;
          end
        end
        ST_RUN: begin
          if (fire) begin
            if (sat_any) sat_flag <= 1'b1;
            if (wrap) begin
              ptr <= '0;
              if (last) state <= ST_DRAIN;
              else pass <= pass + 8'd1;
            end else begin
              ptr <= ptr + AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Accumulation buffer; the final pass never needs write-back.
  always_ff @(posedge clk) begin
    if (fire && !last) mem[ptr] <= acc_wr_v;
  end

  // Output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (fire && last) begin
      out       <= out_v;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sfp_multipass.sv
// Directed bench for sfp_multipass with hand-computed expectations.
// Drives on the falling edge, samples 1 ns later.
module tb_sfp_multipass;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   cfg_depth;
  logic [7:0]   cfg_npass;
  logic         cfg_relu;
  logic [3:0]   cfg_shift;
  logic         busy;
  logic         done;
  logic         sat_flag;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;

  int n_run  = 0;
  int n_fail = 0;

  logic [127:0] beats [64];
  logic [127:0] exv   [64];

  always #5 clk = ~clk;

  sfp_multipass dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_depth (cfg_depth),
    .cfg_npass (cfg_npass),
    .cfg_relu  (cfg_relu),
    .cfg_shift (cfg_shift),
    .busy      (busy),
    .done      (done),
    .sat_flag  (sat_flag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  function automatic logic [127:0] vk(input int base, input int step);
    logic [127:0] r;
    logic [31:0]  v;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      v = 32'(base + k * step);
      r[16*k +: 16] = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] sp(input int v);
    return vk(v, 0);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic kick(input int d, input int p, input int relu,
                      input int sh);
    cfg_depth = 5'(d);
    cfg_npass = 8'(p);
    cfg_relu  = 1'(relu);
    cfg_shift = 4'(sh);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic run_job(input string tag, input int d, input int p,
                         input int relu, input int sh, input int nb,
                         input int ne, input int slo, input int shi,
                         input int mid, input int early_lim,
                         input logic exp_sat);
    int bi = 0;
    int oi = 0;
    int dn = 0;
    int early = 0;
    int bad = 0;
    logic hold = 1'b0;
    logic [127:0] prev = '0;
    kick(d, p, relu, sh);
    check({tag, "_busy"}, 128'(busy), 128'(1));
    for (int cyc = 0; cyc < 400 && dn == 0; cyc++) begin
      out_ready = !(cyc >= slo && cyc <= shi);
      in_valid  = (bi < nb);
      in        = (bi < nb) ? beats[bi] : '0;
      start     = (mid != 0 && cyc == 3);
      if (start) cfg_depth = 5'd1;
      #1;
      if (hold && (out !== prev || !out_valid)) bad++;
      if (out_valid && !out_ready && in_ready && bi >= (p - 1) * d) bad++;
      if (out_valid && bi < early_lim) early++;
      hold = out_valid && !out_ready;
      prev = out;
      if (out_valid && out_ready) begin
        if (oi < ne) check($sformatf("%s_out%0d", tag, oi), out, exv[oi]);
        else bad++;
        oi++;
      end
      if (done) begin
        dn++;
        if (oi != ne) bad++;
      end
      if (in_valid && in_ready) bi++;
      @(negedge clk);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check({tag, "_done_cnt"}, 128'(dn), 128'(1));
    check({tag, "_beats_in"}, 128'(bi), 128'(nb));
    check({tag, "_beats_out"}, 128'(oi), 128'(ne));
    check({tag, "_early_ov"}, 128'(early), 128'(0));
    check({tag, "_protocol"}, 128'(bad), 128'(0));
    check({tag, "_idle"}, {126'(0), busy, done}, 128'(0));
    check({tag, "_sat"}, 128'(sat_flag), 128'(exp_sat));
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    cfg_depth = '0;
    cfg_npass = '0;
    cfg_relu  = 1'b0;
    cfg_shift = '0;
    in_valid  = 1'b0;
    in        = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ctl", {124'(0), busy, done, sat_flag, out_valid}, 128'(0));
    check("rst_out", out, 128'(0));
    check("rst_rdy", 128'(in_ready), 128'(0));
    @(negedge clk);

    // 1: abort a job with reset, then a clean D=1 two-pass job
    kick(4, 2, 0, 0);
    in_valid = 1'b1;
    in       = sp(3);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("t1_pre_done", 128'(done), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t1_abort", {125'(0), busy, done, out_valid}, 128'(0));
    @(negedge clk);
    #1;
    check("t1_nodone", {126'(0), busy, done}, 128'(0));
    @(negedge clk);
    beats[0] = sp(1);
    beats[1] = sp(1);
    exv[0]   = sp(2);
    run_job("t1", 1, 2, 0, 0, 2, 1, -1, -1, 0, 1, 1'b0);

    // 2: single pass with ReLU
    beats[0] = sp(5);
    beats[1] = sp(-7);
    beats[2] = sp(100);
    exv[0]   = sp(5);
    exv[1]   = sp(0);
    exv[2]   = sp(100);
    run_job("t2", 3, 1, 1, 0, 3, 3, -1, -1, 0, 0, 1'b0);

    // 3: three passes, shift by one, no ReLU
    beats[0] = sp(10);
    beats[1] = sp(-1);
    beats[2] = sp(20);
    beats[3] = sp(-1);
    beats[4] = sp(-3);
    beats[5] = sp(-1);
    exv[0]   = sp(13);
    exv[1]   = sp(-2);
    run_job("t3", 2, 3, 0, 1, 6, 2, -1, -1, 0, 4, 1'b0);

    // 4: output saturation both directions
    beats[0] = sp(32767);
    beats[1] = sp(32767);
    exv[0]   = sp(32767);
    run_job("t4p", 1, 2, 0, 0, 2, 1, -1, -1, 0, 1, 1'b1);
    beats[0] = sp(-32768);
    beats[1] = sp(-32768);
    exv[0]   = sp(-32768);
    run_job("t4n", 1, 2, 0, 0, 2, 1, -1, -1, 0, 1, 1'b1);

    // 5: backpressure on cycles 2..5
    beats[0] = sp(11);
    beats[1] = sp(-22);
    beats[2] = sp(33);
    beats[3] = sp(-44);
    for (int i = 0; i < 4; i++) exv[i] = beats[i];
    run_job("t5", 4, 1, 0, 0, 4, 4, 2, 5, 0, 0, 1'b0);

    // 6: npass=0, oversize depth, mid-job start ignored, mixed lanes
    for (int i = 0; i < 16; i++) begin
      beats[i] = vk(i * 8 - 60, 1);
      exv[i]   = beats[i];
    end
    run_job("t6", 21, 0, 0, 0, 16, 16, -1, -1, 1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
